// File: rtl/alu_result_bcd.sv
// alu_result_bcd: iterative double-dabble binary-to-BCD converter with sign and overflow flags
module alu_result_bcd #(
  parameter int W = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        value,
  input  logic                is_signed,
  output logic                busy,
  output logic                done,
  output logic                neg,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);
  localparam int SW = 4*DIGITS;
  localparam int CW = $clog2(W+1);
  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;
  state_t r_state;
  logic [W-1:0] r_mag;
  logic [SW:0] r_scr;
  logic [CW-1:0] r_cnt;
  logic r_neg, r_ovf;
  logic w_neg, w_ovf;
  logic [W-1:0] w_mag;
  logic [SW-1:0] w_adj;
  assign w_neg = is_signed && value[W-1];
  assign w_mag = w_neg ? -value : value;
  // the carry bit holds only the latest shift-out; r_ovf keeps earlier ones
  assign w_ovf = r_ovf | r_scr[SW];
  always_comb begin
    w_adj = r_scr[SW-1:0];
    for (int i = 0; i < DIGITS; i++)
      w_adj[4*i+:4] = r_scr[4*i+:4] >= 4'd5 ? r_scr[4*i+:4] + 4'd3 : r_scr[4*i+:4];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mag    <= '0;
      r_scr    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      neg      <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_mag   <= w_mag;
          r_neg   <= w_neg;
          r_scr   <= '0;
          r_ovf   <= 1'b0;
          r_cnt   <= CW'(W);
          busy    <= 1'b1;
          r_state <= CONVERT;
        end
        CONVERT: begin
          r_scr   <= {w_adj, r_mag[W-1]};
          r_mag   <= r_mag << 1;
          r_ovf   <= w_ovf;
          r_cnt   <= r_cnt - 1'b1;
          r_state <= r_cnt == CW'(1) ? FINISH : CONVERT;
        end
        FINISH: begin
          neg      <= r_neg;
          overflow <= w_ovf;
          bcd      <= w_ovf ? {DIGITS{4'h9}} : r_scr[SW-1:0];
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
